// File: rtl/riscv_alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_alu_pkg
// Description : Shared definitions for the RISC-V ALU self-test sequencer:
//               ALU control encodings, the test-vector record, the golden
//               vector table and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_alu_pkg;

    // ALU control encodings understood by the single-cycle ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Reported as the first failing index when every vector matched
    localparam logic [3:0] NO_FAIL_IDX = 4'hF;

    // The table is addressed by a 4-bit index, so it always has 16 slots
    localparam int BIST_TABLE_DEPTH = 16;

    // One self-test vector: operation, operands and the expected response
    typedef struct packed {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_zero;
    } bist_vec_t;

    // Golden vectors. Slots 8..15 are filler (AND of zeros) so that a run
    // configured for more than 8 vectors still sees self-consistent entries.
    localparam bist_vec_t GOLDEN_TABLE [BIST_TABLE_DEPTH] = '{
        '{ALU_AND, 32'h0000_000F, 32'h0000_000A, 32'h0000_000A, 1'b0},
        '{ALU_OR,  32'h0000_0000, 32'h0000_000A, 32'h0000_000A, 1'b0},
        '{ALU_ADD, 32'h0000_0009, 32'h0000_0001, 32'h0000_000A, 1'b0},
        '{ALU_SUB, 32'h0000_0008, 32'h0000_0002, 32'h0000_0006, 1'b0},
        '{ALU_SLT, 32'h0000_0008, 32'h0000_0009, 32'h0000_0001, 1'b0},
        '{ALU_SLT, 32'h0000_000A, 32'h0000_0009, 32'h0000_0000, 1'b1},
        '{ALU_NOR, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFF5, 1'b0},
        '{ALU_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1},
        '{ALU_AND, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
        '{ALU_AND, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
        '{ALU_AND, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
        '{ALU_AND, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
        '{ALU_AND, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
        '{ALU_AND, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
        '{ALU_AND, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
        '{ALU_AND, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1}
    };

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } bist_state_e;

    // 4-bit increment that sticks at 15 instead of wrapping
    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage : riscv_alu_pkg
`default_nettype wire

// File: rtl/alu_bist_rom.sv
`default_nettype none
// ============================================================================
// Module      : alu_bist_rom
// Description : Combinational index-to-vector lookup into the golden table.
//               Kept as its own block so a product can swap in its own table.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_bist_rom
    import riscv_alu_pkg::*;
(
    input  logic [3:0]  i_idx,
    output logic [3:0]  o_ctl,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_exp_out,
    output logic        o_exp_zero
);

    bist_vec_t w_vec;

    // Pure table read; the 4-bit index covers every slot
    always_comb begin
        w_vec = GOLDEN_TABLE[i_idx];
    end

    assign o_ctl      = w_vec.ctl;
    assign o_a        = w_vec.a;
    assign o_b        = w_vec.b;
    assign o_exp_out  = w_vec.exp_out;
    assign o_exp_zero = w_vec.exp_zero;

endmodule : alu_bist_rom
`default_nettype wire

// File: rtl/riscv_alu_bist.sv
`default_nettype none
// ============================================================================
// Module      : riscv_alu_bist
// Description : Self-test sequencer for the single-cycle RISC-V ALU. Walks the
//               golden vector table, drives ALUctl/A/B, waits for the ALU to
//               settle, compares ALUout/zero and reports pass, a saturating
//               failure count and the index of the first failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_alu_bist
    import riscv_alu_pkg::*;
#(
    parameter int NUM_VECTORS   = 8,   // 1..15
    parameter int SETTLE_CYCLES = 1    // 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  ALUctl,
    output logic [31:0] A,
    output logic [31:0] B,
    input  logic [31:0] ALUout,
    input  logic        zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_count,
    output logic [3:0]  first_fail_idx
);

    localparam logic [3:0] c_LAST_IDX    = 4'(NUM_VECTORS - 1);
    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES);

    bist_state_e r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_settle_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [3:0]  r_fail_count;
    logic [3:0]  r_first_fail_idx;
    logic [3:0]  r_alu_ctl;
    logic [31:0] r_a;
    logic [31:0] r_b;

    logic [3:0]  w_rom_ctl;
    logic [31:0] w_rom_a;
    logic [31:0] w_rom_b;
    logic [31:0] w_rom_exp_out;
    logic        w_rom_exp_zero;
    logic        w_accept;
    logic        w_mismatch;
    logic        w_last_vec;
    logic [3:0]  w_fail_count_upd;

    // The ROM is addressed by the current vector index in every state; in
    // CHECK the index still points at the vector that was driven.
    alu_bist_rom u_rom (
        .i_idx      (r_idx),
        .o_ctl      (w_rom_ctl),
        .o_a        (w_rom_a),
        .o_b        (w_rom_b),
        .o_exp_out  (w_rom_exp_out),
        .o_exp_zero (w_rom_exp_zero)
    );

    // Start acceptance, compare result and the updated failure count
    always_comb begin
        w_accept         = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_mismatch       = (ALUout != w_rom_exp_out) || (zero != w_rom_exp_zero);
        w_last_vec       = (r_idx == c_LAST_IDX);
        w_fail_count_upd = w_mismatch ? sat_inc4(r_fail_count) : r_fail_count;
    end

    // Sequencer: state, vector index, settle counter and busy/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= 4'd0;
            r_settle_cnt <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_state <= ST_DRIVE;
                        r_idx   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    r_settle_cnt <= c_SETTLE_LOAD;
                    r_state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt - 4'd1;
                    // "<=" rather than "==" keeps the FSM from stalling if
                    // the counter were ever loaded with zero
                    if (r_settle_cnt <= 4'd1) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_last_vec) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= ST_DRIVE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // ALU operand/control drive: loaded in DRIVE, held through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_ctl <= 4'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
        end else if (r_state == ST_DRIVE) begin
            r_alu_ctl <= w_rom_ctl;
            r_a       <= w_rom_a;
            r_b       <= w_rom_b;
        end
    end

    // Result bookkeeping: cleared on an accepted start, updated in CHECK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_count     <= 4'd0;
            r_first_fail_idx <= NO_FAIL_IDX;
            r_pass           <= 1'b0;
        end else if (w_accept) begin
            r_fail_count     <= 4'd0;
            r_first_fail_idx <= NO_FAIL_IDX;
            r_pass           <= 1'b0;
        end else if (r_state == ST_CHECK) begin
            r_fail_count <= w_fail_count_upd;
            if (w_mismatch && (r_first_fail_idx == NO_FAIL_IDX)) begin
                r_first_fail_idx <= r_idx;
            end
            // pass becomes visible on the same edge that raises done
            if (w_last_vec) begin
                r_pass <= (w_fail_count_upd == 4'd0);
            end
        end
    end

    assign ALUctl         = r_alu_ctl;
    assign A              = r_a;
    assign B              = r_b;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign fail_count     = r_fail_count;
    assign first_fail_idx = r_first_fail_idx;

endmodule : riscv_alu_bist
`default_nettype wire

// File: tb/tb_riscv_alu_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_alu_bist
// Description : Self-checking bench for riscv_alu_bist. Two sequencers
//               (SETTLE_CYCLES 1 and 3) each sit beside a behavioural ALU
//               that can be corrupted per vector. Expected verdicts come from
//               comparing the corrupted ALU behaviour against the golden
//               vector list; edge counts start at 1 on the start-sampling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_alu_bist;
    import riscv_alu_pkg::*;

    // Golden vectors as stated for the ALU self-test
    localparam logic [3:0]  TV_CTL  [8] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h7, 4'hC, 4'h6};
    localparam logic [31:0] TV_A    [8] = '{32'hF, 32'h0, 32'd9, 32'd8, 32'd8, 32'hA, 32'h0, 32'd5};
    localparam logic [31:0] TV_B    [8] = '{32'hA, 32'hA, 32'd1, 32'd2, 32'd9, 32'd9, 32'hA, 32'd5};
    localparam logic [31:0] TV_OUT  [8] = '{32'hA, 32'hA, 32'hA, 32'd6, 32'd1, 32'd0, 32'hFFFF_FFF5, 32'd0};
    localparam logic        TV_ZERO [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [3:0]  ctl0, ctl1, fc0, fc1, ffi0, ffi1;
    logic [31:0] a0, a1, b0, b1, out0, out1;
    logic        zero0, zero1, busy0, busy1, done0, done1, pass0, pass1;

    logic [31:0] fmask0 [8];
    logic [31:0] fmask1 [8];
    logic        fflip0 [8];
    logic        fflip1 [8];
    logic        ftie0, ftie1;

    int n_vec = 0;
    int n_err = 0;
    int sel   = 0;
    int cyc   = 0;
    int q0[$];
    int q1[$];
    logic [67:0] prev0, prev1;

    logic [3:0]  m_ctl, m_fc, m_ffi;
    logic [31:0] m_a, m_b;
    logic        m_busy, m_done, m_pass;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_alu_bist #(.NUM_VECTORS(8), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .ALUctl(ctl0), .A(a0), .B(b0),
        .ALUout(out0), .zero(zero0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_count(fc0), .first_fail_idx(ffi0)
    );

    riscv_alu_bist #(.NUM_VECTORS(8), .SETTLE_CYCLES(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ALUctl(ctl1), .A(a1), .B(b1),
        .ALUout(out1), .zero(zero1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fc1), .first_fail_idx(ffi1)
    );

    // Behavioural ALU: {zero, result}
    function automatic logic [32:0] alu_ref(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (ctl)
            4'h0:    r = a & b;
            4'h1:    r = a | b;
            4'h2:    r = a + b;
            4'h6:    r = a - b;
            4'h7:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hC:    r = ~(a | b);
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    // Which golden vector is on the ALU inputs (8 = none)
    function automatic int match_idx(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < 8; k++)
            if (ctl == TV_CTL[k] && a == TV_A[k] && b == TV_B[k]) return k;
        return 8;
    endfunction

    always_comb begin
        int m;
        logic [32:0] r;
        m = match_idx(ctl0, a0, b0);
        r = alu_ref(ctl0, a0, b0);
        out0 = r[31:0];
        zero0 = r[32];
        if (m < 8) begin
            out0 = out0 ^ fmask0[m];
            zero0 = zero0 ^ fflip0[m];
        end
        if (ftie0) zero0 = 1'b0;
    end

    always_comb begin
        int m;
        logic [32:0] r;
        m = match_idx(ctl1, a1, b1);
        r = alu_ref(ctl1, a1, b1);
        out1 = r[31:0];
        zero1 = r[32];
        if (m < 8) begin
            out1 = out1 ^ fmask1[m];
            zero1 = zero1 ^ fflip1[m];
        end
        if (ftie1) zero1 = 1'b0;
    end

    assign m_ctl  = (sel == 1) ? ctl1  : ctl0;
    assign m_a    = (sel == 1) ? a1    : a0;
    assign m_b    = (sel == 1) ? b1    : b0;
    assign m_busy = (sel == 1) ? busy1 : busy0;
    assign m_done = (sel == 1) ? done1 : done0;
    assign m_pass = (sel == 1) ? pass1 : pass0;
    assign m_fc   = (sel == 1) ? fc1   : fc0;
    assign m_ffi  = (sel == 1) ? ffi1  : ffi0;

    // Log every change of the driven vector while busy: cycle*16 + vector index
    always @(negedge clk) begin
        if ({ctl0, a0, b0} !== prev0 && busy0) q0.push_back(cyc * 16 + match_idx(ctl0, a0, b0));
        prev0 <= {ctl0, a0, b0};
    end
    always @(negedge clk) begin
        if ({ctl1, a1, b1} !== prev1 && busy1) q1.push_back(cyc * 16 + match_idx(ctl1, a1, b1));
        prev1 <= {ctl1, a1, b1};
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 1) start1 = v; else start0 = v;
    endtask

    task automatic clear_faults();
        for (int k = 0; k < 8; k++) begin
            fmask0[k] = 32'd0; fmask1[k] = 32'd0;
            fflip0[k] = 1'b0;  fflip1[k] = 1'b0;
        end
        ftie0 = 1'b0;
        ftie1 = 1'b0;
    endtask

    // Reference verdict: a vector fails when the (possibly corrupted) ALU
    // response differs from the golden expectation
    task automatic model_run(input int s, output int fails, output int first);
        logic [32:0] r;
        logic [31:0] o;
        logic z;
        fails = 0;
        first = 15;
        for (int k = 0; k < 8; k++) begin
            r = alu_ref(TV_CTL[k], TV_A[k], TV_B[k]);
            o = r[31:0] ^ ((s == 1) ? fmask1[k] : fmask0[k]);
            z = r[32] ^ ((s == 1) ? fflip1[k] : fflip0[k]);
            if ((s == 1) ? ftie1 : ftie0) z = 1'b0;
            if (o !== TV_OUT[k] || z !== TV_ZERO[k]) begin
                if (first == 15) first = k;
                if (fails < 15) fails++;
            end
        end
    endtask

    task automatic check_reset_vals(input int s);
        sel = s;
        #1;
        chk_eq("rst_busy",  m_busy, 0);
        chk_eq("rst_done",  m_done, 0);
        chk_eq("rst_pass",  m_pass, 0);
        chk_eq("rst_fcnt",  m_fc,   0);
        chk_eq("rst_ffi",   m_ffi,  4'hF);
        chk_eq("rst_aluctl", m_ctl, 0);
        chk_eq("rst_a",     m_a,    0);
        chk_eq("rst_b",     m_b,    0);
    endtask

    // One complete run: start held for 'hold' edges, plus random start pulses while busy
    task automatic run_bist(input int s, input int hold, input int n_pulses);
        int settle, exp_cyc, exp_fails, exp_first, done_c, cs, cd, last;
        bit pulse_at [64];
        int qq[$];
        settle  = (s == 1) ? 3 : 1;
        exp_cyc = 8 * (2 + settle) + 1;
        model_run(s, exp_fails, exp_first);
        for (int k = 0; k < 64; k++) pulse_at[k] = 1'b0;
        for (int k = 0; k < n_pulses; k++) pulse_at[$urandom_range(hold + 1, exp_cyc - 1)] = 1'b1;
        sel = s;
        if (s == 1) q1.delete(); else q0.delete();
        done_c = 0; cs = 0; cd = 0;
        @(negedge clk);
        set_start(s, 1'b1);
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                cs = cyc;
                chk_eq("busy_after_start", m_busy, 1);
                chk_eq("done_low_after_start", m_done, 0);
            end
            chk_eq("busy_done_excl", m_busy & m_done, 0);
            if (m_done) begin
                done_c = c;
                cd = cyc;
                break;
            end
            @(negedge clk);
            set_start(s, ((c + 1) <= hold) || ((c + 1 < 64) ? pulse_at[c + 1] : 1'b0));
        end
        @(negedge clk);
        set_start(s, 1'b0);
        if (done_c == 0) begin
            chk_eq("done_timeout", 0, 1);
            return;
        end
        chk_eq("done_cycle", done_c, exp_cyc);
        chk_eq("busy_at_done", m_busy, 0);
        chk_eq("pass", m_pass, (exp_fails == 0) ? 1 : 0);
        chk_eq("fail_count", m_fc, exp_fails);
        chk_eq("first_fail_idx", m_ffi, exp_first);
        if (s == 1) qq = q1; else qq = q0;
        chk_eq("drv_count", qq.size(), 8);
        if (qq.size() > 0) begin
            chk_eq("drv_first_edge", qq[0] / 16 - cs, 1);
            for (int k = 0; k < qq.size() && k < 8; k++) begin
                chk_eq("drv_order", qq[k] % 16, k);
                if (k > 0) chk_eq("drv_gap", qq[k] / 16 - qq[k-1] / 16, 2 + settle);
            end
            last = qq[qq.size() - 1] / 16;
            chk_eq("settle_hold", cd - last, settle + 1);
        end
    endtask

    initial begin
        int nf, k;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        clear_faults();
        repeat (3) @(posedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Golden ALU, single pulse
        run_bist(0, 1, 0);
        // ALUout bit 0 inverted on vector 3
        fmask0[3] = 32'h1;
        run_bist(0, 1, 0);
        // zero tied low
        clear_faults();
        ftie0 = 1'b1;
        run_bist(0, 1, 0);
        // start pulses while busy, then start held in DONE
        clear_faults();
        run_bist(0, 1, 3);
        run_bist(0, 3, 0);

        // Reset during vector 4, then a clean run from vector 0
        sel = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk_eq("pre_rst_aluctl", m_ctl, ALU_SLT);
        chk_eq("pre_rst_a", m_a, 32'd8);
        #2;
        rst_n = 1'b0;
        check_reset_vals(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_bist(0, 1, 0);

        // Longer settle
        run_bist(1, 1, 0);
        ftie1 = 1'b1;
        run_bist(1, 2, 2);

        // Randomized fault patterns
        for (int r = 0; r < 8; r++) begin
            int s;
            s = $urandom_range(0, 1);
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int j = 0; j < nf; j++) begin
                k = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) begin
                    if (s == 1) fmask1[k] = $urandom | (32'h1 << $urandom_range(0, 31));
                    else        fmask0[k] = $urandom | (32'h1 << $urandom_range(0, 31));
                end else begin
                    if (s == 1) fflip1[k] = 1'b1; else fflip0[k] = 1'b1;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                if (s == 1) ftie1 = 1'b1; else ftie0 = 1'b1;
            end
            run_bist(s, $urandom_range(1, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_riscv_alu_bist
`default_nettype wire

// File: doc/riscv_alu_bist.md
# riscv_alu_bist

Self-test sequencer for the single-cycle RISC-V ALU. It drives `ALUctl`/`A`/`B` and checks `ALUout`/`zero` against a fixed table of golden vectors. It sits beside the ALU in the unicycle datapath and takes over the ALU operand/control inputs through an external mux while `busy` is high. On completion it reports pass/fail, a failure count and the index of the first failing vector.

## Interface
- `NUM_VECTORS`, 8: vectors run from the package table (1..15).
- `SETTLE_CYCLES`, 1: wait cycles between driving a vector and sampling the ALU result (1..15).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset. Asynchronous assert, active-low.
- `start`  in  1  single-cycle pulse that starts a run. Ignored while `busy`.
- `ALUctl`  out  4  ALU operation to the ALU under test.
- `A`  out  32  operand A to the ALU.
- `B`  out  32  operand B to the ALU.
- `ALUout`  in  32  ALU result.
- `zero`  in  1  ALU zero flag.
- `busy`  out  1  high from the cycle after `start` until DONE is entered.
- `done`  out  1  high in DONE. Held until the next accepted `start` or reset.
- `pass`  out  1  valid only when `done` is high. 1 when `fail_count` is 0.
- `fail_count`  out  4  number of mismatching vectors, saturating at 15.
- `first_fail_idx`  out  4  index of the first mismatching vector. 4'hF when there was none.

## Operation
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
  - IDLE/DONE with `start`=1 → DRIVE. This clears `idx`, `fail_count` and `done`, and sets `first_fail_idx` to 4'hF.
  - DRIVE: registers `ALUctl`/`A`/`B` from table entry `idx` and loads the settle counter with `SETTLE_CYCLES`. Next state is SETTLE.
  - SETTLE: decrements the counter. Leaves for CHECK when the counter reaches 1.
  - CHECK: compares `ALUout` and `zero` against the expected values, both must match. On a mismatch, `fail_count` increments (saturating) and, if `first_fail_idx` is 4'hF, it takes `idx`. If `idx`==`NUM_VECTORS`-1 the next state is DONE, otherwise `idx` increments and the next state is DRIVE.
- Golden table (ctl, A, B → expected out, expected zero):
  - 0: 0000, 0xF, 0xA → 0xA, 0
  - 1: 0001, 0x0, 0xA → 0xA, 0
  - 2: 0010, 9, 1 → 0xA, 0
  - 3: 0110, 8, 2 → 6, 0
  - 4: 0111, 8, 9 → 1, 0
  - 5: 0111, 0xA, 9 → 0, 1
  - 6: 1100, 0x0, 0xA → 0xFFFFFFF5, 0
  - 7: 0110, 5, 5 → 0, 1
- `A`/`B`/`ALUctl` hold the last vector in DONE and return to 0 only on reset.

## Timing
- Reset values: state IDLE, `ALUctl`=0, `A`=0, `B`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail_idx`=4'hF.
- Each vector costs 2+`SETTLE_CYCLES` cycles. A run ends with `done` rising `NUM_VECTORS`*(2+`SETTLE_CYCLES`)+1 cycles after the `start` edge, which is 25 with the defaults.
- The ALU inputs are stable for at least `SETTLE_CYCLES`+1 cycles before the compare.
- `busy` and `done` are never high together.
- `pass` is registered and updates in the same cycle as `done`.
- Reset mid-run aborts immediately to the reset values. A later `start` runs from vector 0.
- `start` held high for several cycles while DONE restarts the run once. The next acceptance happens only after DONE is reached again.

## Structure
- Package `riscv_alu_pkg`:
  - ALU control constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_NOR=1100.
  - Vector struct {ctl, a, b, exp_out, exp_zero}.
  - Golden table constant.
  - FSM state enum.
- One sub-module, `alu_bist_rom`: a combinational index → vector lookup, kept separate so the table can be swapped per product.

## Test plan
- Golden ALU connected, `start` pulse: `done` at cycle 25, `pass`=1, `fail_count`=0, `first_fail_idx`=F.
- Bench forces `ALUout` bit 0 inverted during vector 3 CHECK: `pass`=0, `fail_count`=1, `first_fail_idx`=3.
- `zero` tied 0: vectors 5 and 7 fail, giving `fail_count`=2, `first_fail_idx`=5.
- `rst_n` asserted during vector 4, released, then `start`: all outputs at reset values, then a clean full run with `pass`=1.
- `start` pulses while `busy`: no restart, `done` still at cycle 25. `start` in DONE: new run, `done` drops the next cycle.
- `SETTLE_CYCLES`=3: `done` at cycle 41, and the ALU inputs are stable 4 cycles before each compare.
